// File: rtl/spi_exe_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : spi_exe_pkg
//  Brief   : Shared frame geometry and controller state encoding.
//  Rev     : 1.0  initial release
// ============================================================================
package spi_exe_pkg;

  localparam int N_DEF     = 4;
  localparam int M_DEF     = 9;
  localparam int FRAME_LEN = N_DEF + 2 * M_DEF;
  localparam int RESP_LEN  = M_DEF + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    CAPT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_frame_ctrl_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module  : sync_edge_det
//  Brief   : Multi-flop synchroniser with rise/fall detection on the synced level.
//  Rev     : 1.0  initial release
// ============================================================================
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : spi_frame_ctrl
//  Brief   : SPI mode-0 slave that delivers {oper,argA,argB} frames to the
//            execution unit and returns the captured result/flags on MISO.
//  Rev     : 1.0  initial release
// ============================================================================
module spi_frame_ctrl
  import spi_exe_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sclk,
  input  logic         i_ss_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic [N-1:0] o_oper,
  output logic         o_valid,
  input  logic [M-1:0] i_result,
  input  logic         i_SF,
  input  logic         i_OF,
  input  logic         i_NF,
  input  logic         i_BF,
  output logic         o_frame_err
);

  localparam int C_FRAME_LEN = N + 2 * M;
  localparam int C_RESP_LEN  = M + 4;
  localparam int C_CNT_W     = $clog2(C_FRAME_LEN + 2);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(C_FRAME_LEN);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(C_FRAME_LEN + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_mosi;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  state_t                 r_state, w_state_nxt;
  logic [C_CNT_W-1:0]     r_cnt;
  logic [C_FRAME_LEN-1:0] r_rx, r_tx;
  logic [C_RESP_LEN-1:0]  r_resp;
  logic                   r_pend, r_valid, r_err;
  logic                   w_start, w_load, w_capt, w_err;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sclk),
    .o_q     (w_sclk_lvl_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Select resets to the deasserted level so reset release never fakes a frame start.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ss_n),
    .o_q     (w_ss_q),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_capt      = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall || r_pend) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          if (r_cnt == C_CNT_FULL) begin
            w_state_nxt = LOAD;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = CAPT;
      end
      CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_resp  <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      o_oper  <= '0;
      o_argA  <= '0;
      o_argB  <= '0;
    end else begin
      r_valid <= w_load;
      r_err   <= w_err;

      if (w_start) begin
        r_cnt  <= '0;
        r_tx   <= {r_resp, {(C_FRAME_LEN - C_RESP_LEN){1'b0}}};
        r_pend <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise) begin
          r_rx <= {r_rx[C_FRAME_LEN-2:0], w_mosi};
          if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + C_CNT_ONE;
        end
        if (w_sclk_fall) r_tx <= {r_tx[C_FRAME_LEN-2:0], 1'b0};
      end

      // A new select that arrives before the controller is idle again is replayed.
      if (w_ss_fall && (r_state == LOAD || r_state == CAPT)) r_pend <= 1'b1;

      if (w_load) begin
        o_oper <= r_rx[C_FRAME_LEN-1 -: N];
        o_argA <= r_rx[2*M-1 -: M];
        o_argB <= r_rx[M-1:0];
      end

      if (w_capt) r_resp <= {i_result, i_SF, i_OF, i_NF, i_BF};
    end
  end

  assign o_miso      = ~w_ss_q & r_tx[C_FRAME_LEN-1];
  assign o_valid     = r_valid;
  assign o_frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_spi_frame_ctrl
//  Brief   : Scoreboard bench: directed SPI frames with a toy execution unit.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_spi_frame_ctrl;
  import spi_exe_pkg::*;

  logic       clk, rst_n, sclk, ss_n, mosi;
  logic       miso, valid, ferr;
  logic [8:0] argA, argB, result;
  logic [3:0] oper;
  logic       SF, OF, NF, BF;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [3:0] op;
    logic [8:0] a;
    logic [8:0] b;
  } ev_t;

  ev_t         q_ev[$];
  logic [12:0] q_miso[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          skip_miso = 0;
  logic [3:0]  cur_op = '0;
  logic [8:0]  cur_a  = '0, cur_b = '0;

  spi_frame_ctrl #(.N(4), .M(9), .SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sclk      (sclk),
    .i_ss_n      (ss_n),
    .i_mosi      (mosi),
    .o_miso      (miso),
    .o_argA      (argA),
    .o_argB      (argB),
    .o_oper      (oper),
    .o_valid     (valid),
    .i_result    (result),
    .i_SF        (SF),
    .i_OF        (OF),
    .i_NF        (NF),
    .i_BF        (BF),
    .o_frame_err (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in execution unit: oper 0 = A-B with borrow, oper 1 = A&B.
  logic [9:0] diff;
  always_comb begin
    diff   = {1'b0, argA} - {1'b0, argB};
    result = '0;
    BF     = 1'b0;
    unique case (oper)
      4'h0:    begin result = diff[8:0]; BF = diff[9]; end
      4'h1:    result = argA & argB;
      default: result = '0;
    endcase
    SF = result[8];
    OF = 1'b0;
    NF = (result == 9'h000);
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    return {10'h0, op, a, b};
  endfunction

  task automatic send(input logic [31:0] data, input int nbits, input int gap);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = data[nbits-1];
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic good_frame(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                            input logic [12:0] exp_resp, input int gap);
    q_miso.push_back(exp_resp);
    q_ev.push_back('{v: 1'b1, e: 1'b0, op: op, a: a, b: b});
    cur_op = op; cur_a = a; cur_b = b;
    send(mk(op, a, b), FRAME_LEN, gap);
  endtask

  task automatic bad_frame(input logic [31:0] data, input int nbits, input logic [12:0] exp_resp);
    q_miso.push_back(exp_resp);
    q_ev.push_back('{v: 1'b0, e: 1'b1, op: cur_op, a: cur_a, b: cur_b});
    send(data, nbits, 20);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Strobe monitor
  initial begin
    ev_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (valid || ferr) begin
        act = '{v: valid, e: ferr, op: oper, a: argA, b: argB};
        n_checks++;
        if (q_ev.size() == 0) begin
          n_fail++;
          $display("FAIL strobe: unexpected v=%0b e=%0b op=%h a=%h b=%h", act.v, act.e, act.op, act.a, act.b);
        end else begin
          exp = q_ev.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL strobe: got v=%0b e=%0b op=%h a=%h b=%h, expected v=%0b e=%0b op=%h a=%h b=%h",
                     act.v, act.e, act.op, act.a, act.b, exp.v, exp.e, exp.op, exp.a, exp.b);
          end
        end
      end
    end
  end

  // MISO monitor: samples at each SCLK rise, scores at SS_n rise
  initial begin
    logic [31:0] act_v, exp_v;
    logic [12:0] exp_r;
    int          nb;
    forever begin
      @(negedge ss_n);
      nb    = 0;
      act_v = '0;
      while (ss_n == 1'b0) begin
        @(posedge sclk or posedge ss_n);
        if (!ss_n && nb < 32) begin
          act_v = {act_v[30:0], miso};
          nb++;
        end
      end
      if (skip_miso) begin
        skip_miso = 1'b0;
      end else begin
        n_checks++;
        if (q_miso.size() == 0) begin
          n_fail++;
          $display("FAIL miso: unexpected frame, got %h", act_v);
        end else begin
          exp_r = q_miso.pop_front();
          exp_v = (nb >= RESP_LEN) ? (32'(exp_r) << (nb - RESP_LEN)) : 32'hFFFF_FFFF;
          if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL miso: got %h (%0d bits), expected %h", act_v, nb, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oper", 32'(oper), 32'h0);
    check("rst_argA", 32'(argA), 32'h0);
    check("rst_argB", 32'(argB), 32'h0);
    check("rst_strobes", {30'h0, valid, ferr}, 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    good_frame(4'h0, 9'h00A, 9'h003, 13'h0000, 20);
    good_frame(4'h0, 9'h003, 9'h005, 13'h0070, 20);
    bad_frame(32'h0015_5555, FRAME_LEN - 1, 13'h1FE9);
    bad_frame(32'h002A_AAAA, FRAME_LEN + 1, 13'h1FE9);

    // Reset in the middle of a frame
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    skip_miso = 1'b1;
    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_oper", 32'(oper), 32'h0);
    check("abort_argA", 32'(argA), 32'h0);
    check("abort_argB", 32'(argB), 32'h0);
    cur_op = '0; cur_a = '0; cur_b = '0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    good_frame(4'h1, 9'h1FF, 9'h0F0, 13'h0000, 20);
    good_frame(4'h0, 9'h00A, 9'h003, 13'h0F00, 3);
    good_frame(4'h1, 9'h155, 9'h0AA, 13'h0070, 20);

    // SCLK activity with select high
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      repeat (4) @(negedge clk);
      check("idle_miso", 32'(miso), 32'h0);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);

    good_frame(4'h0, 9'h001, 9'h001, 13'h0002, 20);

    repeat (20) @(negedge clk);
    check("strobe_queue_empty", 32'(q_ev.size()), 32'h0);
    check("miso_queue_empty", 32'(q_miso.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
SPI slave front end that sits directly upstream of the execution unit. It deserialises one command frame {oper, argA, argB} from the SPI pins and presents it to the unit with a one-cycle valid strobe. It then captures the unit's result and flags, and shifts them back on MISO during the next frame. SPI mode 0 (CPOL=0, CPHA=0), MSB first; all SPI pins are oversampled in the i_clk domain.

Parameters:
N, 4, opcode width (matches execution unit N)
M, 9, operand/result width (matches execution unit M)
SYNC_STAGES, 2, synchroniser depth for i_sclk, i_ss_n, i_mosi (min 2)

Ports:
i_clk  input  1  system clock; must be ≥ 8× SCLK frequency
i_rst_n  input  1  asynchronous active-low reset
i_sclk  input  1  SPI clock, asynchronous to i_clk
i_ss_n  input  1  SPI slave select, active low
i_mosi  input  1  SPI data in
o_miso  output  1  SPI data out
o_argA  output  M  registered operand A to execution unit
o_argB  output  M  registered operand B to execution unit
o_oper  output  N  registered opcode to execution unit
o_valid  output  1  one-cycle strobe: new command on o_argA/o_argB/o_oper
i_result  input  M  execution unit result
i_SF, i_OF, i_NF, i_BF  input  1 each  execution unit flags
o_frame_err  output  1  one-cycle strobe: frame discarded (bad length)

Behaviour:
- Reset (async, i_rst_n=0): o_argA/o_argB/o_oper=0, o_valid=0, o_frame_err=0, o_miso=0, response register=0, bit counter=0, state=IDLE. This applies at any time, including mid-frame. The frame in progress is lost without any error strobe.
- FRAME_LEN = N+2M (22). RESP_LEN = M+4 (13). Frame bit order: oper[N-1]..oper[0], argA[M-1]..argA[0], argB[M-1]..argB[0].
- Pins pass through SYNC_STAGES flops. Edge detection operates on the synchronised sclk and ss_n (previous vs current).
- FSM states: IDLE, SHIFT, LOAD, CAPT.
  - IDLE: on synced ss_n falling edge, clear the bit counter, load tx_shift = {resp_reg, (FRAME_LEN-RESP_LEN) zeros}, go to SHIFT.
  - SHIFT, sclk rising edge: rx_shift <= {rx_shift[FRAME_LEN-2:0], mosi_sync}. Bit counter increments and saturates at FRAME_LEN+1.
  - SHIFT, sclk falling edge: tx_shift shifts left, zero fill.
  - SHIFT, ss_n rising edge: counter==FRAME_LEN → LOAD. Any other count → o_frame_err=1 for one cycle, outputs unchanged, → IDLE.
  - LOAD (1 cycle): register o_oper/o_argA/o_argB from rx_shift; o_valid=1 during the following cycle; → CAPT.
  - CAPT (1 cycle, o_valid high): resp_reg <= {i_result, i_SF, i_OF, i_NF, i_BF}; → IDLE.
- Latency: o_valid is high exactly 2 i_clk cycles after the cycle in which the synced ss_n rise is detected. Operand outputs hold until the next good frame.
- o_miso = tx_shift[FRAME_LEN-1] while synced ss_n is low, else 0. No tristate.
- Before the first completed frame, MISO returns all zeros.
- An ss_n falling edge detected while in LOAD/CAPT is held pending and honoured on entry to IDLE. Minimum ss_n high time is 4 i_clk cycles.
- sclk edges while ss_n is high are ignored.
- Errored frames do not update resp_reg. The next frame re-sends the last good response.

Decomposition:
- Package spi_exe_pkg: FRAME_LEN, RESP_LEN constants derived from N/M defaults; state enum typedef (IDLE, SHIFT, LOAD, CAPT).
- One sub-module, sync_edge_det: parameterised SYNC_STAGES synchroniser with rise/fall outputs. Instantiated for i_sclk and i_ss_n. i_mosi uses the synchroniser only.

Test Plan:
- Frame oper=4'h0, argA=9'h00A, argB=9'h003 (22 bits) → o_valid one cycle, o_oper=0, o_argA=10, o_argB=3, o_frame_err=0.
- Second frame after the first, with the exe unit connected → first 13 MISO bits = 9'b000000111, SF=0, OF=0, NF=0, BF=0; remaining 9 bits 0.
- 21-bit frame and 23-bit frame → o_frame_err pulse each, no o_valid, o_argA/o_argB/o_oper unchanged, next MISO response repeats the previous good result.
- i_rst_n low at bit 10 of a frame, released, then a good frame oper=4'h1, A=9'h1FF, B=9'h0F0 → no valid/err from the aborted frame; good frame gives o_argA=9'h1FF, o_argB=9'h0F0, o_oper=1.
- Back-to-back frames with 4-cycle ss_n gap, SCLK = i_clk/8 → both o_valid strobes present, second frame's MISO carries the first frame's result.
- SCLK toggling with ss_n high → no counter change, no strobes, o_miso=0.
